// File: rtl/mac_psum_accum.sv
// Reduces a bit-plane of per-lane products to a partial sum through a two-stage
// adder tree, then shift-accumulates planes MSB-first into one dot product per frame.
module mac_psum_accum #(
  parameter int N       = 256,
  parameter int W_BITS  = 4,
  parameter int IN_BITS = 8,
  parameter int PSUM_W  = W_BITS + $clog2(N),
  parameter int ACC_W   = PSUM_W + IN_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N*W_BITS-1:0]   product_array,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic [ACC_W-1:0]      result,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err_len
);

  localparam int NG    = N / 16;
  localparam int GSW   = W_BITS + 4;
  localparam int CNT_W = $clog2(IN_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IN_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IN_BITS + 1);

  logic [NG*GSW-1:0] gsum_d, gsum_q;
  logic              s1_valid_d, s1_valid_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
  logic [PSUM_W-1:0] psum_d, psum_q;
  logic              s2_valid_d, s2_valid_q, s2_first_d, s2_first_q, s2_last_d, s2_last_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              busy_d, busy_q, err_d, err_q, done_d, done_q;
  logic [ACC_W-1:0]  result_d, result_q;
  logic              out_valid_d, out_valid_q;

  // Stage 1: one 16-lane sum per group.
  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_group
      logic [GSW-1:0] sum_c;
      always_comb begin
        sum_c = '0;
        for (int j = 0; j < 16; j++) begin
          sum_c = sum_c + GSW'(product_array[W_BITS*(gi*16+j) +: W_BITS]);
        end
      end
      assign gsum_d[gi*GSW +: GSW] = sum_c;
    end
  endgenerate

  always_comb begin
    // Flags are qualified by in_valid so stray first/last on idle cycles vanish.
    s1_valid_d = in_valid;
    s1_first_d = in_valid & in_first;
    s1_last_d  = in_valid & in_last;

    psum_d = '0;
    for (int g = 0; g < NG; g++) begin
      psum_d = psum_d + PSUM_W'(gsum_q[g*GSW +: GSW]);
    end
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
  end

  // Stage 3: accumulate; completion is latched into result one cycle later.
  always_comb begin
    logic             accept;
    logic [ACC_W-1:0] acc_new;
    logic [CNT_W-1:0] cnt_new;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    acc_new = acc_q;
    cnt_new = cnt_q;

    if (s2_valid_q) begin
      if (s2_first_q) begin
        accept  = 1'b1;
        acc_new = ACC_W'(psum_q);
        cnt_new = CNT_W'(1);
      end else if (busy_q) begin
        accept  = 1'b1;
        acc_new = {acc_q[ACC_W-2:0], 1'b0} + ACC_W'(psum_q);
        cnt_new = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    if (accept) begin
      acc_d  = acc_new;
      cnt_d  = cnt_new;
      busy_d = 1'b1;
      if (s2_last_q) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (cnt_new != CNT_FULL) err_d = 1'b1;
      end
    end

    result_d    = done_q ? acc_q : result_q;
    out_valid_d = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gsum_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      psum_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      gsum_q      <= gsum_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      psum_q      <= psum_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_mac_psum_accum.sv
// Bench for mac_psum_accum: directed frame table, hand-written corner sequences and
// random frames checked every cycle against a frame-level arithmetic reference.
module tb_mac_psum_accum;

  localparam int N  = 256;
  localparam int WB = 4;
  localparam int NW = N * WB;
  localparam int HIST = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] product_array;
  logic          in_valid, in_first, in_last;
  logic [19:0]   result;
  logic          out_valid, busy, err_len;
  logic [12:0]   result1;
  logic          out_valid1, busy1, err_len1;

  mac_psum_accum #(.N(N), .W_BITS(WB), .IN_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .product_array(product_array),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .result(result), .out_valid(out_valid), .busy(busy), .err_len(err_len)
  );

  mac_psum_accum #(.N(N), .W_BITS(WB), .IN_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .product_array(product_array),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .result(result1), .out_valid(out_valid1), .busy(busy1), .err_len(err_len1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Reference model state
  typedef struct { int due; longint val; } emit_t;
  emit_t  emit_q[$];
  bit     m_open;
  bit     m_err;
  longint m_acc;
  int     m_cnt;
  longint last_res;
  bit     open_hist[HIST];
  bit     err_hist[HIST];

  typedef struct {
    int         pat;
    int         nplanes;
    int         gap;
    logic [19:0] exp_result;
    logic       exp_err;
  } frame_t;
  frame_t tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic longint lane_sum(input logic [NW-1:0] v);
    longint s = 0;
    for (int i = 0; i < N; i++) s += v[WB*i +: WB];
    return s;
  endfunction

  function automatic logic [NW-1:0] vec_for(input int pat, input int plane);
    logic [NW-1:0] v = '0;
    case (pat)
      0: v = '1;
      1: v[3:0] = (plane % 2 == 0) ? 4'd1 : 4'd0;
      2: v[3:0] = 4'd2;
      3: v[3:0] = 4'd1;
      default: for (int i = 0; i < N; i++) v[WB*i +: WB] = 4'(i % 16);
    endcase
    return v;
  endfunction

  function automatic logic [NW-1:0] rand_vec();
    logic [NW-1:0] v;
    for (int w = 0; w < NW/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // Frame-level semantics: value = sum of plane sums weighted MSB-first.
  task automatic model_sample(input logic v, input logic f, input logic l, input logic [NW-1:0] vec);
    bit accepted = 0;
    if (v) begin
      longint ps = lane_sum(vec);
      if (f) begin
        m_open = 1; m_acc = ps; m_cnt = 1; accepted = 1;
      end else if (m_open) begin
        m_acc = m_acc * 2 + ps; m_cnt++; accepted = 1;
      end else begin
        m_err = 1;
      end
      if (accepted && l) begin
        emit_t e;
        m_open = 0;
        if (m_cnt != 8) m_err = 1;
        e.due = cycle + 3;
        e.val = m_acc % (64'd1 << 20);
        emit_q.push_back(e);
      end
    end
    open_hist[cycle] = m_open;
    err_hist[cycle]  = m_err;
  endtask

  task automatic check_outputs();
    bit exp_ov = 0;
    if (emit_q.size() > 0 && emit_q[0].due == cycle) begin
      exp_ov = 1;
      last_res = emit_q[0].val;
      void'(emit_q.pop_front());
      $display("[TB] cycle %0d frame done: result %0d err_len %0b", cycle, result, err_len);
    end
    chk("out_valid", out_valid, exp_ov);
    chk("result", result, last_res);
    chk("busy", busy, (cycle >= 2) ? open_hist[cycle-2] : 1'b0);
    chk("err_len", err_len, (cycle >= 2) ? err_hist[cycle-2] : 1'b0);
  endtask

  task automatic step(input logic v, input logic f, input logic l, input logic [NW-1:0] vec);
    in_valid = v; in_first = f; in_last = l; product_array = vec;
    @(posedge clk);
    cycle++;
    model_sample(v, f, l, vec);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_first = 0; in_last = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err_len", err_len, 0);
    emit_q.delete();
    m_open = 0; m_err = 0; m_acc = 0; m_cnt = 0; last_res = 0;
    open_hist[cycle] = 0; err_hist[cycle] = 0;
    if (cycle >= 1) begin open_hist[cycle-1] = 0; err_hist[cycle-1] = 0; end
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic run_frame(input int pat, input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      step(1'b1, p == 0, p == n - 1, vec_for(pat, p));
      if (p < n - 1) idle(gap);
    end
    idle(3);
  endtask

  initial begin
    tbl[0] = '{pat: 0, nplanes: 8, gap: 0, exp_result: 20'd979200, exp_err: 1'b0};
    tbl[1] = '{pat: 1, nplanes: 8, gap: 2, exp_result: 20'd170,    exp_err: 1'b0};
    tbl[2] = '{pat: 2, nplanes: 8, gap: 0, exp_result: 20'd510,    exp_err: 1'b0};
    tbl[3] = '{pat: 3, nplanes: 5, gap: 0, exp_result: 20'd31,     exp_err: 1'b1};

    rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0; product_array = '0;
    @(negedge clk);
    do_reset();

    // Restart: frame A abandoned by a new first, only B is reported.
    for (int p = 0; p < 3; p++) step(1'b1, p == 0, 1'b0, vec_for(3, p));
    run_frame(2, 8, 0);
    chk("restart_result", result, 510);
    chk("restart_err_len", err_len, 0);

    foreach (tbl[k]) begin
      run_frame(tbl[k].pat, tbl[k].nplanes, tbl[k].gap);
      chk($sformatf("tbl%0d_out_valid", k), out_valid, 1);
      chk($sformatf("tbl%0d_result", k), result, tbl[k].exp_result);
      chk($sformatf("tbl%0d_err_len", k), err_len, tbl[k].exp_err);
    end
    idle(4);
    chk("err_sticky", err_len, 1);

    // Orphan plane while idle.
    do_reset();
    step(1'b1, 1'b0, 1'b0, vec_for(3, 0));
    idle(3);
    chk("orphan_err_len", err_len, 1);
    chk("orphan_no_pulse", out_valid, 0);

    // One-plane frame on both builds.
    do_reset();
    run_frame(4, 1, 0);
    chk("single_result", result, 1920);
    chk("single_err_len8", err_len, 1);
    chk("single_out_valid1", out_valid1, 1);
    chk("single_result1", result1, 1920);
    chk("single_err_len1", err_len1, 0);

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    for (int p = 0; p < 4; p++) step(1'b1, p == 0, 1'b0, vec_for(3, p));
    do_reset();
    run_frame(3, 8, 0);
    chk("post_reset_result", result, 255);
    chk("post_reset_err_len", err_len, 0);

    // Random frames with bubbles, stray idle flags, orphans and odd lengths.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(1, 11);
      bit orphan = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) n = 8;
      for (int p = 0; p < n; p++) begin
        step(1'b1, (p == 0) && !orphan, p == n - 1, rand_vec());
        for (int g = $urandom_range(0, 2); g > 0; g--)
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_vec());
      end
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
